// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg
// Shared constants and FSM encoding for the double-buffered VGA frame store.
//   FB_DATA_W  : pixel width, matches the vga_machine pixel bus
//   FB_ADDR_W  : pixel address width, address = {y[5:0], x[5:0]}
//   fb_state_t : frame-buffer controller states
package vga_fb_pkg;

    localparam int FB_DATA_W = 8;
    localparam int FB_ADDR_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_CLEAR   = 2'd2
    } fb_state_t;

endpackage

// File: rtl/vga_fb_bank.sv
// vga_fb_bank
// One 2^ADDR_W x DATA_W pixel bank: synchronous write port, asynchronous read.
// Ports:
//   clk   : system clock
//   we    : write enable, sampled at the rising edge
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : combinational read data
module vga_fb_bank
    import vga_fb_pkg::*;
#(
    parameter int DATA_W = FB_DATA_W,
    parameter int ADDR_W = FB_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: the array has no reset so it maps onto RAM; a reset would force
    // thousands of flops. Pixel contents after reset are simply undefined.
    // NOTE: clocked state is always assigned with <= so every flop samples
    // its inputs before any of them update.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/vga_frame_buffer.sv
// vga_frame_buffer
// Double-buffered 64x64 frame store feeding vga_machine. The GPU writes the
// back bank; vga_machine reads the front bank. A swap waits for the next
// v_sync falling edge so the display never tears, and can be followed by a
// full clear of the new back bank.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   wr_valid/wr_ready   : GPU write handshake into the back bank
//   wr_addr, wr_data    : GPU write address / pixel
//   swap_req            : request bank exchange (taken in IDLE only)
//   swap_clear          : clear new back bank after the swap
//   clear_value         : fill value for the clear pass
//   swap_ack            : one-cycle pulse when the front bank changes
//   busy                : swap pending or clear in progress
//   front_sel           : bank currently displayed
//   v_sync              : active-low vertical sync from vga_machine
//   vga_addr, vga_data  : combinational front-bank read port
module vga_frame_buffer
    import vga_fb_pkg::*;
#(
    parameter int DATA_W = FB_DATA_W,
    parameter int ADDR_W = FB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              swap_req,
    input  logic              swap_clear,
    input  logic [DATA_W-1:0] clear_value,
    output logic              swap_ack,
    output logic              busy,
    output logic              front_sel,
    input  logic              v_sync,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_data
);

    fb_state_t         state;
    logic              v_sync_q;
    logic              clear_flag;
    logic [DATA_W-1:0] clear_val;
    logic [ADDR_W-1:0] clear_cnt;

    logic              vs_fall;
    logic              wr_fire;
    logic              clearing;
    logic              back_we;
    logic [ADDR_W-1:0] back_addr;
    logic [DATA_W-1:0] back_data;
    logic [DATA_W-1:0] rd0;
    logic [DATA_W-1:0] rd1;

    assign vs_fall  = v_sync_q & ~v_sync;
    // wr_ready is high exactly in IDLE, so it doubles as the write gate.
    assign wr_fire  = wr_valid & wr_ready;
    assign clearing = (state == ST_CLEAR);

    // Both GPU writes and clear writes target the back bank (~front_sel);
    // they never overlap because wr_ready is low during CLEAR.
    assign back_we   = wr_fire | clearing;
    assign back_addr = clearing ? clear_cnt : wr_addr;
    assign back_data = clearing ? clear_val : wr_data;

    vga_fb_bank #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_bank0 (
        .clk   (clk),
        .we    (back_we & front_sel),
        .waddr (back_addr),
        .wdata (back_data),
        .raddr (vga_addr),
        .rdata (rd0)
    );

    vga_fb_bank #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_bank1 (
        .clk   (clk),
        .we    (back_we & ~front_sel),
        .waddr (back_addr),
        .wdata (back_data),
        .raddr (vga_addr),
        .rdata (rd1)
    );

    assign vga_data = front_sel ? rd1 : rd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            wr_ready   <= 1'b1;
            busy       <= 1'b0;
            swap_ack   <= 1'b0;
            front_sel  <= 1'b0;
            v_sync_q   <= 1'b1;
            clear_flag <= 1'b0;
            clear_val  <= '0;
            clear_cnt  <= '0;
        end else begin
            v_sync_q <= v_sync;
            swap_ack <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (swap_req) begin
                        clear_flag <= swap_clear;
                        clear_val  <= clear_value;
                        state      <= ST_WAIT_VS;
                        wr_ready   <= 1'b0;
                        busy       <= 1'b1;
                    end
                end

                ST_WAIT_VS: begin
                    if (vs_fall) begin
                        front_sel <= ~front_sel;
                        swap_ack  <= 1'b1;
                        if (clear_flag) begin
                            state <= ST_CLEAR;
                        end else begin
                            state    <= ST_IDLE;
                            wr_ready <= 1'b1;
                            busy     <= 1'b0;
                        end
                    end
                end

                ST_CLEAR: begin
                    // Counter wraps to 0 after the last address, ready for
                    // the next clear pass.
                    clear_cnt <= clear_cnt + 1'b1;
                    if (clear_cnt == {ADDR_W{1'b1}}) begin
                        state    <= ST_IDLE;
                        wr_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                end

                default: begin
                    state    <= ST_IDLE;
                    wr_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_frame_buffer.sv
// tb_vga_frame_buffer
// Scoreboard bench for vga_frame_buffer. Stimulus updates a two-bank array
// model and queues expected front-bank reads and swap acknowledgements;
// independent monitors drive the read port / watch swap_ack and compare.
module tb_vga_frame_buffer;

    localparam int AW    = 12;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          swap_req;
    logic          swap_clear;
    logic [DW-1:0] clear_value;
    logic          swap_ack;
    logic          busy;
    logic          front_sel;
    logic          v_sync;
    logic [AW-1:0] vga_addr;
    logic [DW-1:0] vga_data;

    vga_frame_buffer #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .swap_req    (swap_req),
        .swap_clear  (swap_clear),
        .clear_value (clear_value),
        .swap_ack    (swap_ack),
        .busy        (busy),
        .front_sel   (front_sel),
        .v_sync      (v_sync),
        .vga_addr    (vga_addr),
        .vga_data    (vga_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } rd_exp_t;

    rd_exp_t exp_q[$];
    logic    ack_q[$];

    // Reference model: two plain pixel arrays plus which one is displayed.
    logic [DW-1:0] mem   [2][DEPTH];
    bit            known [2][DEPTH];
    int            front;
    bit            pend_clr;
    logic [DW-1:0] pend_val;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Read monitor: presents each queued address and compares the pixel.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            vga_addr = exp_q[0].addr;
            #1;
            check(exp_q[0].name, {24'd0, vga_data}, {24'd0, exp_q[0].data});
            void'(exp_q.pop_front());
        end
    end

    // Ack monitor: every swap_ack pulse must match one queued swap.
    always @(negedge clk) begin
        if (swap_ack === 1'b1) begin
            if (ack_q.size() == 0) begin
                check("swap_ack_unexpected", {31'd0, swap_ack}, 32'd0);
            end else begin
                check("front_sel_at_ack", {31'd0, front_sel}, {31'd0, ack_q[0]});
                void'(ack_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_read(input string name, input logic [AW-1:0] a);
        rd_exp_t e;
        if (known[front][a]) begin
            e.name = name;
            e.addr = a;
            e.data = mem[front][a];
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 6000) begin
            @(posedge clk);
            n++;
        end
        check("read_queue_drained", exp_q.size(), 0);
        exp_q.delete();
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        check("wr_ready_before_write", {31'd0, wr_ready}, 32'd1);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
        mem[1-front][a]   = d;
        known[1-front][a] = 1'b1;
    endtask

    task automatic start_swap(input bit clr, input logic [DW-1:0] val,
                              input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        swap_req    = 1'b1;
        swap_clear  = clr;
        clear_value = val;
        if (wr) begin
            wr_valid = 1'b1;
            wr_addr  = a;
            wr_data  = d;
        end
        tick();
        swap_req   = 1'b0;
        swap_clear = 1'b0;
        wr_valid   = 1'b0;
        if (wr) begin
            mem[1-front][a]   = d;
            known[1-front][a] = 1'b1;
        end
        pend_clr = clr;
        pend_val = val;
        check("busy_after_req", {31'd0, busy}, 32'd1);
        check("wr_ready_after_req", {31'd0, wr_ready}, 32'd0);
    endtask

    // Produces one v_sync falling edge; returns in the swap_ack cycle.
    task automatic fire_vsync();
        wait_drain();
        v_sync = 1'b1;
        tick();
        ack_q.push_back(front == 0);
        front = 1 - front;
        if (pend_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[1-front][i]   = pend_val;
                known[1-front][i] = 1'b1;
            end
        end
        v_sync = 1'b0;
        tick();
        @(negedge clk);
        #2;
        check("swap_ack_seen", ack_q.size(), 0);
        ack_q.delete();
    endtask

    // Counts busy cycles from the swap_ack cycle onward; pokes the ignored
    // inputs (swap_req, v_sync edges) while the clear runs.
    task automatic wait_clear();
        int cnt = 0;
        while (busy && cnt < 5000) begin
            if (cnt == 5)   swap_req = 1'b1;
            if (cnt == 10)  v_sync   = 1'b1;
            if (cnt == 20)  v_sync   = 1'b0;
            if (cnt == 100) swap_req = 1'b0;
            cnt++;
            tick();
        end
        swap_req = 1'b0;
        check("clear_busy_cycles", cnt, 4096);
        check("wr_ready_after_clear", {31'd0, wr_ready}, 32'd1);
        check("front_sel_after_clear", {31'd0, front_sel}, front);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] addrs[$];
        logic [AW-1:0] a;

        rst = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        swap_req = 1'b0; swap_clear = 1'b0; clear_value = '0;
        v_sync = 1'b1; vga_addr = '0;
        front = 0; pend_clr = 1'b0; pend_val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            known[0][i] = 1'b0;
            known[1][i] = 1'b0;
        end

        repeat (3) tick();
        check("reset_front_sel", {31'd0, front_sel}, 32'd0);
        check("reset_wr_ready", {31'd0, wr_ready}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_swap_ack", {31'd0, swap_ack}, 32'd0);
        rst = 1'b1;
        tick();

        // Write then swap.
        do_write(12'h041, 8'hA5);
        start_swap(1'b0, 8'h00, 1'b0, '0, '0);
        repeat (4) tick();
        fire_vsync();
        check("front_sel_after_swap", {31'd0, front_sel}, 32'd1);
        push_read("write_then_swap", 12'h041);

        // Randomised rounds; each also drops v_sync while IDLE.
        for (int r = 0; r < 6; r++) begin
            wait_drain();
            v_sync = 1'b1; tick();
            v_sync = 1'b0; tick(); tick();
            v_sync = 1'b1; tick();
            check("idle_vsync_no_swap", {31'd0, front_sel}, front);
            addrs.delete();
            repeat ($urandom_range(10, 30)) begin
                a = AW'($urandom_range(0, DEPTH - 1));
                addrs.push_back(a);
                do_write(a, DW'($urandom));
            end
            start_swap(1'b0, DW'($urandom), 1'b0, '0, '0);
            repeat ($urandom_range(0, 20)) tick();
            fire_vsync();
            for (int k = 0; k < 8; k++) begin
                push_read("random_round", addrs[$urandom_range(0, addrs.size() - 1)]);
            end
        end

        // Swap pending with swap_req held and writes attempted.
        wait_drain();
        do_write(12'h123, 8'h5A);
        start_swap(1'b0, 8'h00, 1'b0, '0, '0);
        for (int i = 0; i < 1000; i++) begin
            swap_req = 1'b1;
            wr_valid = 1'b1;
            wr_addr  = 12'h123;
            wr_data  = 8'hEE;
            tick();
        end
        check("pending_front_sel", {31'd0, front_sel}, front);
        check("pending_wr_ready", {31'd0, wr_ready}, 32'd0);
        check("pending_busy", {31'd0, busy}, 32'd1);
        swap_req = 1'b0;
        wr_valid = 1'b0;
        fire_vsync();
        push_read("pending_write_blocked", 12'h123);

        // Clear pass, then a second swap shows the cleared bank.
        start_swap(1'b1, 8'h3C, 1'b0, '0, '0);
        fire_vsync();
        wait_clear();
        start_swap(1'b0, 8'h00, 1'b0, '0, '0);
        fire_vsync();
        for (int i = 0; i < DEPTH; i++) begin
            push_read("clear_fill", AW'(i));
        end

        // Write and swap request in the same IDLE cycle.
        wait_drain();
        start_swap(1'b0, 8'h00, 1'b1, 12'hFFF, 8'h77);
        repeat (3) tick();
        fire_vsync();
        push_read("simultaneous_write_req", 12'hFFF);

        // Reset in the middle of a clear pass.
        wait_drain();
        start_swap(1'b1, 8'h99, 1'b0, '0, '0);
        fire_vsync();
        repeat (2000) tick();
        rst = 1'b0;
        #1;
        check("midclear_reset_front_sel", {31'd0, front_sel}, 32'd0);
        check("midclear_reset_wr_ready", {31'd0, wr_ready}, 32'd1);
        check("midclear_reset_busy", {31'd0, busy}, 32'd0);
        check("midclear_reset_swap_ack", {31'd0, swap_ack}, 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            known[1-front][i] = 1'b0;
        end
        front    = 0;
        pend_clr = 1'b0;
        tick();
        rst = 1'b1;
        do_write(12'h200, 8'hC3);
        start_swap(1'b0, 8'h00, 1'b0, '0, '0);
        fire_vsync();
        push_read("post_reset_write", 12'h200);

        wait_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
